nack_req_rr_mux: RTL and testbench
==================================

Name: nack_req_rr_mux

Overview:
- Downstream consumer of the team's N-way round-robin arbiter.
- Merges N per-flow NACK request streams (valid/ready, multi-beat with last) into one registered output stream for the NACK packet builder.
- Arbitrates at packet granularity: a granted source keeps the output until its last beat.
- The round-robin pointer advances only on an accepted first beat.

Parameters:
- N, 16, number of input request channels (N >= 2).
- DW, 64, data width per beat.
- SW, $clog2(N), width of the source-index field.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- in_valid  in  N  per-channel beat valid.
- in_data  in  N*DW  per-channel beat data; channel i occupies [i*DW +: DW].
- in_last  in  N  per-channel last-beat flag.
- in_ready  out  N  per-channel beat accepted this cycle.
- out_valid  out  1  registered output beat valid.
- out_data  out  DW  registered output data.
- out_last  out  1  registered output last flag.
- out_src  out  SW  index of the channel that produced the output beat.
- out_ready  in  1  downstream accepts the output beat.
- busy  out  1  high while in LOCKED state (mid-packet).

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset values:
  - out_valid=0, out_data=0, out_last=0, out_src=0, busy=0.
  - state=IDLE, lock_idx=0.
  - pointer={N{1'b1}}, so index 0 has highest priority.
- accept = ~out_valid | out_ready. The output register loads a new beat only when accept=1, giving full throughput of one beat per cycle.
- Handshake: AXI-stream rules.
  - Sources hold in_valid, in_data and in_last stable until in_ready.
  - A transfer on channel i occurs when in_valid[i] & in_ready[i].
- in_ready is combinational. The out_ready -> in_ready path is intentional. in_ready is at most one-hot.
- Round-robin pick (IDLE only):
  - masked = in_valid & pointer.
  - If |masked, grant the lowest-index set bit of masked; otherwise grant the lowest-index set bit of in_valid.
- Pointer update, only on a first-beat transfer from granted index g: pointer <= bits strictly above g set, all others 0.
  - When g=N-1 the pointer becomes 0, so the next pick falls back to the unmasked path.
- No pointer change on idle cycles, stalled cycles, or continuation beats.
- State IDLE:
  - in_ready[g] = accept & in_valid[g]; all other in_ready bits are 0.
  - On transfer: out_data/out_last/out_src <= beat/in_last[g]/g, out_valid <= 1.
  - If in_last[g]=0, set lock_idx=g and go to LOCKED; otherwise stay in IDLE.
- State LOCKED:
  - Only lock_idx is eligible: in_ready[lock_idx] = accept. All other channels see in_ready 0 even if valid.
  - On transfer, load the output register.
  - If in_last=1, return to IDLE. The next arbitration happens the following cycle.
- No transfer with accept=1: out_valid <= 0 (output bubble).
- Stall (out_valid=1, out_ready=0): all output registers hold, all in_ready=0, state and pointer unchanged.
- No request: in_ready=0, pointer holds, output drains normally.
- Single-beat packets: every beat has in_last=1, so the block stays in IDLE and re-arbitrates every cycle.
- Latency: an input beat appears on out_* the cycle after its transfer.
- Reset mid-packet: lock and output are dropped immediately (out_valid=0 after the clock). The downstream builder sees a truncated packet and discards on its own reset. Upstream must restart packets after reset.
- No buffering beyond the single output register. No data is lost or duplicated under any combination of valid/ready.

Test Plan:
1. Reset idle (N=4):
   - Stimulus: assert rst 2 cycles, all in_valid=0.
   - Required: out_valid=0, in_ready=4'b0000, busy=0 during reset and afterwards.
2. Fair rotation:
   - Stimulus: N=4, all channels valid, single-beat packets, out_ready=1 continuous.
   - Required: out_src sequence 0,1,2,3,0,1; out_valid=1 every cycle starting one cycle after the first transfer.
3. Sparse wrap:
   - Stimulus: only channels 1 and 3 valid, single-beat.
   - Required: out_src 1,3,1,3. After granting 3 the pointer is 0 and the pick returns to 1.
4. Packet lock:
   - Stimulus: channel 2 sends a 3-beat packet (last on beat 3) while channel 0 is continuously valid.
   - Required:
     - out_src 2,2,2 then 0; busy=1 during beats 1-2 of the packet.
     - in_ready[0]=0 until the cycle after channel 2's last beat.
     - out_last=1 only on the third beat.
5. Backpressure:
   - Stimulus: out_valid=1 with out_data=0xA5, out_ready=0 for 5 cycles.
   - Required: out_data stays 0xA5, in_ready=0, pointer unchanged. Once out_ready=1 is restored, rotation resumes with the next expected index.
6. Reset mid-packet:
   - Stimulus: rst asserted after beat 1 of a 3-beat packet on channel 1.
   - Required: next cycle out_valid=0, busy=0, pointer all-ones. The first post-reset grant goes to the lowest-index valid channel.

Source files
------------

// File: rtl/nack_req_rr_mux.sv
// Packet-granular round-robin merge of N NACK request streams into one
// registered valid/ready output stream for the NACK packet builder.
module nack_req_rr_mux #(
    parameter int N  = 16,
    parameter int DW = 64,
    parameter int SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    in_valid,
    input  logic [N*DW-1:0] in_data,
    input  logic [N-1:0]    in_last,
    output logic [N-1:0]    in_ready,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic            out_last,
    output logic [SW-1:0]   out_src,
    input  logic            out_ready,
    output logic            busy
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   lock_idx_q, lock_idx_d;
    logic [N-1:0]    ptr_q, ptr_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic            out_last_q, out_last_d;
    logic [SW-1:0]   out_src_q, out_src_d;

    logic [N-1:0]    masked;
    logic [SW-1:0]   m_idx, u_idx, pick_idx, grant_idx;
    logic            accept, grant_vld, xfer;
    logic [DW-1:0]   sel_data;
    logic            sel_last;

    // Lowest-index set bit of the masked and unmasked request vectors.
    always_comb begin
        masked = in_valid & ptr_q;
        m_idx  = '0;
        u_idx  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (masked[i])   m_idx = SW'(i);
            if (in_valid[i]) u_idx = SW'(i);
        end
        pick_idx = (|masked) ? m_idx : u_idx;
    end

    always_comb begin
        accept    = ~out_valid_q | out_ready;
        grant_idx = (state_q == LOCKED) ? lock_idx_q : pick_idx;
        grant_vld = in_valid[grant_idx];
        sel_data  = in_data[grant_idx*DW +: DW];
        sel_last  = in_last[grant_idx];
        // Ready is held low during reset so no beat is consumed and then dropped.
        xfer      = accept & grant_vld & ~rst;

        in_ready = '0;
        if (accept && !rst) begin
            if (state_q == LOCKED)
                in_ready[lock_idx_q] = 1'b1;
            else if (|in_valid)
                in_ready[pick_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        lock_idx_d  = lock_idx_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;

        if (accept) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_data_d = sel_data;
                out_last_d = sel_last;
                out_src_d  = grant_idx;
            end
        end

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    // Only a first beat moves the pointer: everything above g stays eligible.
                    for (int i = 0; i < N; i++)
                        ptr_d[i] = (i > int'(grant_idx));
                    if (!sel_last) begin
                        lock_idx_d = grant_idx;
                        state_d    = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (xfer && sel_last)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lock_idx_q  <= '0;
            ptr_q       <= '1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
        end else begin
            state_q     <= state_d;
            lock_idx_q  <= lock_idx_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_src   = out_src_q;
    assign busy      = (state_q == LOCKED);

endmodule

// File: tb/tb_nack_req_rr_mux.sv
// Directed vector bench for nack_req_rr_mux with N=4; channel i always
// presents data 8'hA5+i so the expected output data follows from out_src.
module tb_nack_req_rr_mux;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int SW = 2;

    logic            clk;
    logic            rst;
    logic [N-1:0]    in_valid;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_last;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic [SW-1:0]   out_src;
    logic            out_ready;
    logic            busy;

    nack_req_rr_mux #(.N(N), .DW(DW), .SW(SW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_last (out_last),
        .out_src  (out_src),
        .out_ready(out_ready),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic [3:0]   v;
        logic [3:0]   l;
        logic         ordy;
        logic [3:0]   e_rdy;
        logic         e_ov;
        logic [1:0]   e_src;
        logic         e_last;
        logic         e_busy;
    } vec_t;

    vec_t tbl[$];
    int   nvec = 0;
    int   errs = 0;

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [3:0] l,
                                input logic ordy, input logic [3:0] e_rdy, input logic e_ov,
                                input logic [1:0] e_src, input logic e_last, input logic e_busy);
        vec_t t;
        t.rst = r; t.v = v; t.l = l; t.ordy = ordy;
        t.e_rdy = e_rdy; t.e_ov = e_ov; t.e_src = e_src; t.e_last = e_last; t.e_busy = e_busy;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        if (got !== exp) begin
            errs++;
            $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, got, exp);
        end
    endtask

    // Drive at negedge, check combinational ready before the edge, registered outputs after.
    task automatic step(input vec_t t);
        logic [DW-1:0] exp_data;
        @(negedge clk);
        rst       = t.rst;
        in_valid  = t.v;
        in_last   = t.l;
        out_ready = t.ordy;
        #1;
        chk("in_ready", nvec, 32'(in_ready), 32'(t.e_rdy));
        @(posedge clk);
        #1;
        chk("out_valid", nvec, 32'(out_valid), 32'(t.e_ov));
        chk("busy", nvec, 32'(busy), 32'(t.e_busy));
        if (t.e_ov) begin
            exp_data = 8'hA5 + 8'(t.e_src);
            chk("out_src", nvec, 32'(out_src), 32'(t.e_src));
            chk("out_last", nvec, 32'(out_last), 32'(t.e_last));
            chk("out_data", nvec, 32'(out_data), 32'(exp_data));
        end
        nvec++;
    endtask

    initial begin
        rst = 1'b1; in_valid = '0; in_last = '0; out_ready = 1'b1;
        for (int i = 0; i < N; i++) in_data[i*DW +: DW] = 8'hA5 + 8'(i);

        // reset idle
        tbl.push_back(mk(1, 4'h0, 4'h0, 1, 4'h0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4'h0, 4'h0, 1, 4'h0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'h0, 4'h0, 1, 4'h0, 0, 0, 0, 0));
        // fair rotation, single-beat packets
        tbl.push_back(mk(0, 4'hF, 4'hF, 1, 4'h1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 4'hF, 4'hF, 1, 4'h2, 1, 1, 1, 0));
        tbl.push_back(mk(0, 4'hF, 4'hF, 1, 4'h4, 1, 2, 1, 0));
        tbl.push_back(mk(0, 4'hF, 4'hF, 1, 4'h8, 1, 3, 1, 0));
        tbl.push_back(mk(0, 4'hF, 4'hF, 1, 4'h1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 4'hF, 4'hF, 1, 4'h2, 1, 1, 1, 0));
        // sparse wrap from a fresh pointer
        tbl.push_back(mk(1, 4'h0, 4'h0, 1, 4'h0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'hA, 4'hA, 1, 4'h2, 1, 1, 1, 0));
        tbl.push_back(mk(0, 4'hA, 4'hA, 1, 4'h8, 1, 3, 1, 0));
        tbl.push_back(mk(0, 4'hA, 4'hA, 1, 4'h2, 1, 1, 1, 0));
        tbl.push_back(mk(0, 4'hA, 4'hA, 1, 4'h8, 1, 3, 1, 0));
        tbl.push_back(mk(0, 4'h0, 4'h0, 1, 4'h0, 0, 0, 0, 0));
        // ch1 single beat leaves pointer 1100 so ch2 wins against ch0
        tbl.push_back(mk(0, 4'h2, 4'h2, 1, 4'h2, 1, 1, 1, 0));
        // packet lock: 3-beat packet on ch2, ch0 waiting
        tbl.push_back(mk(0, 4'h5, 4'h1, 1, 4'h4, 1, 2, 0, 1));
        tbl.push_back(mk(0, 4'h5, 4'h1, 1, 4'h4, 1, 2, 0, 1));
        tbl.push_back(mk(0, 4'h5, 4'h5, 1, 4'h4, 1, 2, 1, 0));
        tbl.push_back(mk(0, 4'h1, 4'h1, 1, 4'h1, 1, 0, 1, 0));
        // backpressure: 0xA5 from ch0 held 5 cycles, then rotation resumes at 1
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk(0, 4'hF, 4'hF, 0, 4'h0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 4'hF, 4'hF, 1, 4'h2, 1, 1, 1, 0));
        tbl.push_back(mk(0, 4'hF, 4'hF, 1, 4'h4, 1, 2, 1, 0));

        for (int k = 0; k < tbl.size(); k++) step(tbl[k]);

        // reset mid-packet: lock dropped, pointer back to all-ones (picks 1 not 2)
        step(mk(1, 4'h0, 4'h0, 1, 4'h0, 0, 0, 0, 0));
        step(mk(0, 4'h2, 4'h0, 1, 4'h2, 1, 1, 0, 1));
        step(mk(1, 4'h3, 4'h0, 1, 4'h0, 0, 0, 0, 0));
        step(mk(0, 4'h6, 4'h6, 1, 4'h2, 1, 1, 1, 0));

        // stall while locked: output and lock hold, ready drops
        step(mk(0, 4'h6, 4'h0, 1, 4'h4, 1, 2, 0, 1));
        step(mk(0, 4'h6, 4'h4, 0, 4'h0, 1, 2, 0, 1));
        step(mk(0, 4'h6, 4'h4, 0, 4'h0, 1, 2, 0, 1));
        step(mk(0, 4'h6, 4'h4, 1, 4'h4, 1, 2, 1, 0));
        step(mk(0, 4'h2, 4'h2, 1, 4'h2, 1, 1, 1, 0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

endmodule
